uart_cmd_rx: RTL and testbench

//  Serial command front end for pong_top: receives 8N1 UART bytes on RsRx, decodes

---
 rtl/uart_cmd_rx.sv | 136 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that turns paddle keys into held button bits for the pong game.
// Raw received bytes and framing-error strobes are exported for debug.

module uart_hold_ctr #(
  parameter int unsigned HOLD_CLKS = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic clr_i,
  output logic on_o
);
  localparam int HW = $clog2(HOLD_CLKS + 1);

  logic [HW-1:0] cnt_q, cnt_d;

  // A reload wins over a clear so a key always restarts its own hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = HW'(HOLD_CLKS);
    else if (clr_i)        cnt_d = '0;
    else if (cnt_q != '0)  cnt_d = cnt_q - HW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign on_o = (cnt_q != '0);
endmodule

module uart_cmd_rx #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 9_600,
  parameter int unsigned HOLD_CLKS = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [3:0] btn,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam int unsigned CPB  = CLK_HZ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int          CW   = $clog2(CPB + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, rx_byte_q;
  logic          rx_valid_q, frame_err_q;
  logic          rx_s;

  // Preset to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (!rx_s) begin
          state_q <= S_START;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
        S_START: if (cnt_q == CW'(HALF - 1)) begin
          cnt_q   <= '0;
          state_q <= rx_s ? S_IDLE : S_DATA;
        end else cnt_q <= cnt_q + CW'(1);
        S_DATA: if (cnt_q == CW'(CPB - 1)) begin
          cnt_q   <= '0;
          shift_q <= {rx_s, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= S_STOP;
        end else cnt_q <= cnt_q + CW'(1);
        S_STOP: if (cnt_q == CW'(CPB - 1)) begin
          cnt_q <= '0;
          if (rx_s) begin
            rx_byte_q  <= shift_q;
            rx_valid_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= S_BREAK;
          end
        end else cnt_q <= cnt_q + CW'(1);
        // A held break must not be re-read as a stream of start bits.
        S_BREAK: if (rx_s) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decode on the same edge that raises rx_valid so btn moves with it.
  logic       good_stb;
  logic [7:0] lc;
  logic [3:0] load, clr;

  assign good_stb = (state_q == S_STOP) && (cnt_q == CW'(CPB - 1)) && rx_s;
  assign lc       = (shift_q >= 8'h41 && shift_q <= 8'h5A) ? (shift_q | 8'h20) : shift_q;
  assign load     = good_stb ? {lc == 8'h6B, lc == 8'h69, lc == 8'h73, lc == 8'h77} : 4'b0;
  assign clr      = (good_stb && lc == 8'h20) ? 4'hF : {load[2], load[3], load[0], load[1]};

  for (genvar g = 0; g < 4; g++) begin : g_hold
    uart_hold_ctr #(.HOLD_CLKS(HOLD_CLKS)) u_hold (
      .clk    (clk),
      .reset_n(reset_n),
      .load_i (load[g]),
      .clr_i  (clr[g]),
      .on_o   (btn[g])
    );
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: a spec-rate instance (100-clk hold) plus a long-hold instance
// whose holds outlast a 160-clk frame, so key overlap, exclusion and space-clear are visible.

module tb_uart_cmd_rx;
  localparam int CPB = 16;
  localparam int HS  = 100;
  localparam int HL  = 1000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [3:0] btn_s, btn_l;
  logic [7:0] rx_byte_s, rx_byte_l;
  logic       rx_valid_s, rx_valid_l, frame_err_s, frame_err_l;

  uart_cmd_rx #(.CLK_HZ(160), .BAUD(10), .HOLD_CLKS(HS)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .btn(btn_s), .rx_byte(rx_byte_s),
    .rx_valid(rx_valid_s), .frame_err(frame_err_s));

  uart_cmd_rx #(.CLK_HZ(160), .BAUD(10), .HOLD_CLKS(HL)) dut_l (
    .clk(clk), .reset_n(reset_n), .rx(rx), .btn(btn_l), .rx_byte(rx_byte_l),
    .rx_valid(rx_valid_l), .frame_err(frame_err_l));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [7:0] data; bit good; } ev_t;
  ev_t        evq[$];
  ev_t        cur_ev;
  int         until_s[4], until_l[4];
  logic [7:0] exp_byte;
  logic [3:0] exp_s, exp_l;
  int         ev_seen = 0, last_ev_cyc = 0, start_cyc = 0;
  logic       last_valid, last_err, post_pend = 1'b0, both_seen = 1'b0;
  logic [3:0] post_btn_s, post_btn_l;

  // 0..3 = button index, 4 = space, -1 = ignored
  function automatic int key_idx(input logic [7:0] b);
    logic [7:0] c;
    c = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    case (c)
      8'h77:   return 0;
      8'h73:   return 1;
      8'h69:   return 2;
      8'h6B:   return 3;
      8'h20:   return 4;
      default: return -1;
    endcase
  endfunction

  function automatic void apply_key(input int k, input int t);
    if (k == 4) begin
      for (int n = 0; n < 4; n++) begin until_s[n] = t; until_l[n] = t; end
    end else if (k >= 0) begin
      until_s[k] = t + HS;  until_l[k] = t + HL;
      until_s[k ^ 1] = t;   until_l[k ^ 1] = t;
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", 32'({btn_l, btn_s, rx_byte_l, rx_byte_s,
                                rx_valid_l, rx_valid_s, frame_err_l, frame_err_s}), 32'd0);
      for (int n = 0; n < 4; n++) begin until_s[n] = 0; until_l[n] = 0; end
      exp_byte = 8'h00;
      evq.delete();
      post_pend = 1'b0;
    end else begin
      if (post_pend) begin
        post_btn_s = btn_s;
        post_btn_l = btn_l;
        post_pend  = 1'b0;
      end
      if (rx_valid_s | rx_valid_l | frame_err_s | frame_err_l) begin
        if (evq.size() == 0) begin
          chk("unexpected_strobe", 32'({rx_valid_l, frame_err_l, rx_valid_s, frame_err_s}), 32'd0);
        end else begin
          cur_ev = evq.pop_front();
          chk("strobe_kind", 32'({rx_valid_l, frame_err_l, rx_valid_s, frame_err_s}),
              32'({cur_ev.good, !cur_ev.good, cur_ev.good, !cur_ev.good}));
          if (cur_ev.good) begin
            exp_byte = cur_ev.data;
            apply_key(key_idx(cur_ev.data), cyc);
          end
          last_ev_cyc = cyc;
          last_valid  = rx_valid_s;
          last_err    = frame_err_s;
          ev_seen++;
          post_pend   = 1'b1;
        end
      end
      for (int n = 0; n < 4; n++) begin
        exp_s[n] = (cyc < until_s[n]);
        exp_l[n] = (cyc < until_l[n]);
      end
      chk("btn", 32'({btn_l, btn_s}), 32'({exp_l, exp_s}));
      chk("rx_byte", 32'({rx_byte_l, rx_byte_s}), 32'({exp_byte, exp_byte}));
      if (btn_l[1:0] == 2'b11 || btn_l[3:2] == 2'b11) both_seen = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_bit, input int brk);
    int         seen0;
    logic [9:0] fr;
    seen0     = ev_seen;
    start_cyc = cyc;
    evq.push_back('{data: d, good: stop_bit});
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (!stop_bit) begin
      rx = 1'b0;
      repeat (brk) @(posedge clk);
      #1;
      idle(CPB);
    end
    rx = 1'b1;
    for (int k = 0; k < 40 && ev_seen == seen0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("strobe_seen", 32'(ev_seen - seen0), 32'd1);
    chk_rng("strobe_latency", last_ev_cyc - start_cyc, 150, 160);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [3:0] exp_btn_s;
    logic [3:0] exp_btn_l;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       tv[8];
  logic [7:0] pool[10];
  int         seen0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'h77, 1'b1, 20, 1'b1, 1'b0, 4'h1, 4'h1, 8'h77};
    tv[1] = '{8'h57, 1'b1, 20, 1'b1, 1'b0, 4'h1, 4'h1, 8'h57};
    tv[2] = '{8'h73, 1'b1, 60, 1'b1, 1'b0, 4'h2, 4'h2, 8'h73};
    tv[3] = '{8'h49, 1'b1, 10, 1'b1, 1'b0, 4'h4, 4'h6, 8'h49};
    tv[4] = '{8'h6B, 1'b0, 10, 1'b0, 1'b1, 4'h0, 4'h6, 8'h49};
    tv[5] = '{8'h6B, 1'b1, 10, 1'b1, 1'b0, 4'h8, 4'hA, 8'h6B};
    tv[6] = '{8'h41, 1'b1, 10, 1'b1, 1'b0, 4'h0, 4'hA, 8'h41};
    tv[7] = '{8'h20, 1'b1, 10, 1'b1, 1'b0, 4'h0, 4'h0, 8'h20};
    pool  = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h69, 8'h49, 8'h6B, 8'h4B, 8'h20, 8'h00};

    // Reset and idle line
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(50);
    @(negedge clk);
    chk("idle_outputs", 32'({btn_l, btn_s, rx_byte_s, rx_valid_s, frame_err_s}), 32'd0);
    @(posedge clk);
    #1;

    // Single 'w': bit0 held for exactly HS clocks from the rx_valid cycle
    send(8'h77, 1'b1, 0);
    chk("w_btn_at_valid", 32'(post_btn_s), 32'h1);
    while (cyc < last_ev_cyc + HS - 1) @(negedge clk);
    chk("hold_last_cycle", 32'(btn_s[0]), 32'd1);
    @(negedge clk);
    chk("hold_expired", 32'(btn_s[0]), 32'd0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 8; r++) begin
      idle(tv[r].gap);
      send(tv[r].data, tv[r].stop, 2 * CPB);
      chk($sformatf("vec%0d_valid", r), 32'(last_valid), 32'(tv[r].exp_valid));
      chk($sformatf("vec%0d_err", r), 32'(last_err), 32'(tv[r].exp_err));
      chk($sformatf("vec%0d_btn", r), 32'({post_btn_l, post_btn_s}),
          32'({tv[r].exp_btn_l, tv[r].exp_btn_s}));
      chk($sformatf("vec%0d_byte", r), 32'(rx_byte_s), 32'(tv[r].exp_byte));
    end

    // Short low glitch on an idle line must be rejected
    idle(20);
    seen0 = ev_seen;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    chk("glitch_no_strobe", 32'(ev_seen - seen0), 32'd0);
    send(8'h77, 1'b1, 0);
    send(8'h6B, 1'b1, 0);
    chk("w_k_held_long", 32'(post_btn_l), 32'h9);
    send(8'h20, 1'b1, 0);
    chk("space_clears", 32'({post_btn_l, post_btn_s}), 32'h0);

    // Reset during data bit 4 of 'i'
    idle(10);
    send(8'h57, 1'b1, 0);
    idle(10);
    seen0 = ev_seen;
    for (int i = 0; i < 5; i++) begin
      rx = (i == 0) ? 1'b0 : tv[0].data[0] ^ 1'b1 ^ 8'h69 >> (i - 1) & 1'b1;
      rx = (i == 0) ? 1'b0 : pool[4][i-1];
      repeat (CPB) @(posedge clk);
      #1;
    end
    chk("btn_before_abort", 32'(btn_l[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_drop", 32'({btn_l, btn_s, rx_valid_l, rx_valid_s}), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(30);
    chk("abort_no_strobe", 32'(ev_seen - seen0), 32'd0);
    send(8'h69, 1'b1, 0);
    chk("i_after_reset", 32'({post_btn_l, post_btn_s}), 32'h44);
    chk("i_byte_after_reset", 32'(rx_byte_s), 32'h69);

    // Randomized traffic against the model, including back-to-back frames
    for (int j = 0; j < 24; j++) begin
      logic [7:0] b;
      bit         st;
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 9)];
      st = ($urandom_range(0, 7) != 0);
      idle(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40));
      send(b, st, $urandom_range(0, 30));
    end
    idle(20);

    chk("no_same_player_both", 32'(both_seen), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
